// File: rtl/can_command_responder.sv
// can_command_responder: CAN init sequencer and command-frame decoder.
// Optional link watchdog enabled by defining CAN_CMD_WATCHDOG_EN.
module can_command_responder #(
  parameter int          DATA_WIDTH  = 16,
  parameter logic [10:0] CMD_ID      = 11'h120,
  parameter int          INIT_CYCLES = 1000,
  parameter int          WDT_CYCLES  = 50_000_000,
  parameter logic [7:0]  STOP_CODE   = 8'h00
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    can_init_enable_in,
  output logic                    can_init_done_out,
  input  logic                    rx_valid_in,
  input  logic [10:0]             rx_id_in,
  input  logic [3:0]              rx_dlc_in,
  input  logic [31:0]             rx_data_in,
  output logic                    rx_ack_out,
  output logic [7:0]              rx_error_count_out,
  output logic [DATA_WIDTH/2-1:0] band_breaks_mode_out,
  output logic [DATA_WIDTH/2-1:0] pmsm_start_stop_mode_out,
  output logic [DATA_WIDTH/4-1:0] pmsm_work_mode_out,
  output logic                    wdt_timeout_out
);

  localparam int BW = DATA_WIDTH / 2;
  localparam int WW = DATA_WIDTH / 4;
  localparam int IW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DONE,
    READY
  } state_t;

  state_t state, state_nx;

  logic          init_q;
  logic          init_rise;
  logic [IW-1:0] init_cnt;
  logic          init_last;
  logic [7:0]    b0, b1, b2, b3;
  logic          rx_ok;
  logic          rx_bad;
  logic          wdt_fire;

  assign b0 = rx_data_in[7:0];
  assign b1 = rx_data_in[15:8];
  assign b2 = rx_data_in[23:16];
  assign b3 = rx_data_in[31:24];

  assign init_rise = can_init_enable_in & ~init_q;
  assign init_last = (init_cnt == IW'(INIT_CYCLES - 1));

  assign rx_ok = rx_valid_in && (state == READY)
              && (rx_id_in == CMD_ID)
              && (rx_dlc_in == 4'd4)
              && (b3 == (b0 ^ b1 ^ b2));

  assign rx_bad = rx_valid_in && (state == READY) && !rx_ok;

  assign can_init_done_out = (state == DONE);

  // Previous init level; reset high so a level held through reset is no edge
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) init_q <= 1'b1;
    else       init_q <= can_init_enable_in;
  end

  // State register
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; an init edge restarts from any state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = IDLE;
      INIT:    if (init_last) state_nx = DONE;
      DONE:    state_nx = READY;
      READY:   state_nx = READY;
      default: state_nx = IDLE;
    endcase
    if (init_rise) state_nx = INIT;
  end

  // Init sequence counter
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      init_cnt <= '0;
    else if (init_rise)
      init_cnt <= '0;
    else if (state == INIT && !init_last)
      init_cnt <= init_cnt + 1'b1;
  end

  // Decoded command outputs, ack pulse and reject counter
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_ack_out               <= 1'b0;
      rx_error_count_out       <= '0;
      band_breaks_mode_out     <= '0;
      pmsm_start_stop_mode_out <= '0;
      pmsm_work_mode_out       <= '0;
    end else begin
      rx_ack_out <= 1'b0;
      if (init_rise) begin
        rx_error_count_out       <= '0;
        band_breaks_mode_out     <= '0;
        pmsm_start_stop_mode_out <= '0;
        pmsm_work_mode_out       <= '0;
      end else if (rx_ok) begin
        rx_ack_out               <= 1'b1;
        band_breaks_mode_out     <= BW'(b0);
        pmsm_start_stop_mode_out <= BW'(b1);
        pmsm_work_mode_out       <= WW'(b2[3:0]);
      end else begin
        if (rx_bad && rx_error_count_out != 8'hFF)
          rx_error_count_out <= rx_error_count_out + 8'd1;
        if (wdt_fire)
          pmsm_start_stop_mode_out <= BW'(STOP_CODE);
      end
    end
  end

`ifdef CAN_CMD_WATCHDOG_EN
  localparam int TW = $clog2(WDT_CYCLES + 1);

  logic [TW-1:0] wdt_cnt;

  assign wdt_fire = (state == READY) && !rx_ok && !init_rise
                 && (wdt_cnt == TW'(WDT_CYCLES - 1));

  // Watchdog counter; parks one past terminal so it fires only once
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wdt_cnt         <= '0;
      wdt_timeout_out <= 1'b0;
    end else begin
      wdt_timeout_out <= wdt_fire;
      if (init_rise || rx_ok)
        wdt_cnt <= '0;
      else if (state == READY && wdt_cnt != TW'(WDT_CYCLES))
        wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  logic unused_wdt_cfg;

  assign unused_wdt_cfg  = ^{STOP_CODE, 32'(WDT_CYCLES)};
  assign wdt_fire        = 1'b0;
  assign wdt_timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_can_command_responder.sv
// tb_can_command_responder: directed bench with scoreboard queue
// for the CAN init sequencer and command decoder.
module tb_can_command_responder;

  localparam int INIT_CYC = 10;
  localparam int WDT_CYC  = 100;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        init_en;
  logic        done;
  logic        rx_valid;
  logic [10:0] rx_id;
  logic [3:0]  rx_dlc;
  logic [31:0] rx_data;
  logic        ack;
  logic [7:0]  err;
  logic [7:0]  band;
  logic [7:0]  ss;
  logic [3:0]  wm;
  logic        tmo;

  always #5 sys_clk = ~sys_clk;

  can_command_responder #(
    .DATA_WIDTH (16),
    .CMD_ID     (11'h120),
    .INIT_CYCLES(INIT_CYC),
    .WDT_CYCLES (WDT_CYC),
    .STOP_CODE  (8'h00)
  ) dut (
    .sys_clk                 (sys_clk),
    .reset                   (reset),
    .can_init_enable_in      (init_en),
    .can_init_done_out       (done),
    .rx_valid_in             (rx_valid),
    .rx_id_in                (rx_id),
    .rx_dlc_in               (rx_dlc),
    .rx_data_in              (rx_data),
    .rx_ack_out              (ack),
    .rx_error_count_out      (err),
    .band_breaks_mode_out    (band),
    .pmsm_start_stop_mode_out(ss),
    .pmsm_work_mode_out      (wm),
    .wdt_timeout_out         (tmo)
  );

  typedef struct {
    logic       ack;
    logic [7:0] band;
    logic [7:0] ss;
    logic [3:0] wm;
    logic [7:0] err;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  logic [7:0] m_band, m_ss, m_err;
  logic [3:0] m_wm;
  int         m_wdt;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One READY-phase cycle: drive, predict, push, clock, pop, compare
  task automatic step(input logic        v,
                      input logic [10:0] id,
                      input logic [3:0]  dlc,
                      input logic [31:0] d);
    exp_t e;
    logic ok;
    rx_valid = v;
    rx_id    = id;
    rx_dlc   = dlc;
    rx_data  = d;
    ok = v && (id == 11'h120) && (dlc == 4'd4)
      && (d[31:24] == (d[7:0] ^ d[15:8] ^ d[23:16]));
    e.tmo = 1'b0;
    e.ack = ok;
    if (ok) begin
      m_band = d[7:0];
      m_ss   = d[15:8];
      m_wm   = d[19:16];
      m_wdt  = 0;
    end else begin
      if (v && m_err != 8'hFF) m_err = m_err + 8'd1;
`ifdef CAN_CMD_WATCHDOG_EN
      if (m_wdt == WDT_CYC - 1) begin
        m_ss  = 8'h00;
        e.tmo = 1'b1;
      end
      if (m_wdt < WDT_CYC) m_wdt++;
`endif
    end
    e.band = m_band;
    e.ss   = m_ss;
    e.wm   = m_wm;
    e.err  = m_err;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    chk("ack",  32'(ack),  32'(e.ack));
    chk("band", 32'(band), 32'(e.band));
    chk("ss",   32'(ss),   32'(e.ss));
    chk("wm",   32'(wm),   32'(e.wm));
    chk("err",  32'(err),  32'(e.err));
    chk("tmo",  32'(tmo),  32'(e.tmo));
    chk("done", 32'(done), 0);
    rx_valid = 1'b0;
  endtask

  initial begin
    int n_done, n_ack, n_tmo, first;

    reset    = 1'b1;
    init_en  = 1'b1;
    rx_valid = 1'b0;
    rx_id    = 11'h120;
    rx_dlc   = 4'd4;
    rx_data  = 32'h06030104;
    tick();
    tick();
    chk("rst_done", 32'(done), 0);
    chk("rst_ack",  32'(ack),  0);
    chk("rst_err",  32'(err),  0);
    chk("rst_band", 32'(band), 0);
    chk("rst_ss",   32'(ss),   0);
    chk("rst_wm",   32'(wm),   0);
    chk("rst_tmo",  32'(tmo),  0);

    // Level held through reset, plus a frame in IDLE
    reset  = 1'b0;
    n_done = 0;
    n_ack  = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) rx_valid = 1'b1;
      if (i == 4) rx_valid = 1'b0;
      tick();
      if (done) n_done++;
      if (ack) n_ack++;
    end
    chk("idle_done", n_done, 0);
    chk("idle_ack",  n_ack,  0);
    chk("idle_err",  32'(err), 0);

    // Init sequence with a frame arriving during INIT
    init_en = 1'b0;
    tick();
    init_en = 1'b1;
    n_done  = 0;
    n_ack   = 0;
    first   = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 3) rx_valid = 1'b1;
      if (i == 4) rx_valid = 1'b0;
      tick();
      if (ack) n_ack++;
      if (done) begin
        n_done++;
        if (first == 0) first = i;
      end
    end
    chk("init_first",  first,  INIT_CYC + 1);
    chk("init_pulses", n_done, 1);
    chk("init_ack",    n_ack,  0);
    chk("init_err",    32'(err), 0);

    m_band = 8'h00;
    m_ss   = 8'h00;
    m_wm   = 4'h0;
    m_err  = 8'h00;
    m_wdt  = 0;

    // Idle READY cycles: no second done pulse with level still high
    for (int i = 0; i < 8; i++) step(1'b0, 11'h120, 4'd4, 32'h0);

    // Valid command frame
    step(1'b1, 11'h120, 4'd4, 32'h06030104);
    chk("valid_band", 32'(band), 32'h04);
    chk("valid_ss",   32'(ss),   32'h01);
    chk("valid_wm",   32'(wm),   32'h3);

    // Three rejects
    step(1'b1, 11'h120, 4'd4, 32'h07030104);
    step(1'b1, 11'h121, 4'd4, 32'h06030104);
    step(1'b1, 11'h120, 4'd3, 32'h06030104);
    chk("rej_err",  32'(err),  3);
    chk("rej_band", 32'(band), 32'h04);

    // Saturation with back-to-back bad frames
    for (int i = 0; i < 300; i++)
      step(1'b1, 11'h121, 4'd4, $urandom);
    chk("sat_err", 32'(err), 255);

    // Start frame then silence
    step(1'b1, 11'h120, 4'd4, 32'h06050102);
    n_tmo = 0;
    first = 0;
    for (int i = 1; i <= 250; i++) begin
      step(1'b0, 11'h120, 4'd4, 32'h0);
      if (tmo) begin
        n_tmo++;
        if (first == 0) first = i;
      end
    end
`ifdef CAN_CMD_WATCHDOG_EN
    chk("wdt_pulses", n_tmo, 1);
    chk("wdt_when",   first, WDT_CYC);
    chk("wdt_ss",     32'(ss), 32'h00);
`else
    chk("wdt_pulses", n_tmo, 0);
    chk("wdt_ss",     32'(ss), 32'h01);
`endif

    // Restart in the middle of INIT
    init_en = 1'b0;
    tick();
    init_en = 1'b1;
    n_done  = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (done) n_done++;
    end
    init_en = 1'b0;
    tick();
    if (done) n_done++;
    init_en = 1'b1;
    first   = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        n_done++;
        if (first == 0) first = i;
      end
    end
    chk("rst_first",  first,  INIT_CYC + 1);
    chk("rst_pulses", n_done, 1);
    chk("rst_band2",  32'(band), 0);
    chk("rst_ss2",    32'(ss),   0);
    chk("rst_wm2",    32'(wm),   0);
    chk("rst_err2",   32'(err),  0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/can_command_responder.md
# can_command_responder

CAN-side responder to the system control unit's CAN initialisation and command interface. On an init request it runs a timed controller-initialisation sequence and returns a one-cycle done pulse. In the ready state it validates incoming command frames from the CAN frame receiver and holds the decoded brake mode, start/stop command and work mode on registered outputs for the control unit. An optional link watchdog forces a stop command when command traffic ceases.

## Interface

Parameters:
- DATA_WIDTH, 16: project data width; brake and start/stop outputs are DATA_WIDTH/2 bits, work mode is DATA_WIDTH/4 bits.
- CMD_ID, 11'h120: standard CAN identifier of command frames.
- INIT_CYCLES, 1000: length of the init sequence in sys_clk cycles (≥1).
- WDT_CYCLES, 50_000_000: watchdog timeout in cycles (≥2).
- STOP_CODE, 8'h00: start/stop value forced on watchdog timeout.

Ports:
- sys_clk, in, 1: single clock for the block.
- reset, in, 1: asynchronous, active-high reset.
- can_init_enable_in, in, 1: init request; rising edge is the trigger.
- can_init_done_out, out, 1: one-cycle pulse at the end of the init sequence.
- rx_valid_in, in, 1: one-cycle frame strobe from the frame receiver.
- rx_id_in, in, 11: frame identifier.
- rx_dlc_in, in, 4: data length code.
- rx_data_in, in, 32: bytes 0–3 at [7:0], [15:8], [23:16], [31:24].
- rx_ack_out, out, 1: one-cycle pulse, frame accepted.
- rx_error_count_out, out, 8: saturating count of rejected frames.
- band_breaks_mode_out, out, DATA_WIDTH/2: brake mode.
- pmsm_start_stop_mode_out, out, DATA_WIDTH/2: start/stop command.
- pmsm_work_mode_out, out, DATA_WIDTH/4: work mode.
- wdt_timeout_out, out, 1: one-cycle watchdog-timeout pulse.

## Operation

- **Reset values.** All outputs are 0 and the state is IDLE while reset is asserted.
- **Edge detection.** can_init_enable_in is registered once. A rising edge is registered high and previous low.
- **IDLE.** Frames are ignored and not counted. A rising edge moves the block to INIT.
- **INIT.** The counter runs from 0 to INIT_CYCLES-1, then the block moves to DONE.
  - On entry, the three mode outputs, rx_error_count_out and the watchdog counter are cleared.
  - Frames arriving in INIT are ignored and not counted.
- **DONE.** can_init_done_out is high for exactly this one cycle, then the block moves to READY.
- **READY.** Every frame is validated and either accepted or rejected.
- **Restart.** A rising edge of can_init_enable_in in any state, including INIT, restarts INIT with the counter at 0 and the outputs cleared.
- **Frame validation.** A frame is accepted only when all of these hold:
  - rx_valid_in is high and the state is READY;
  - rx_id_in equals CMD_ID;
  - rx_dlc_in equals 4;
  - byte3 equals byte0 XOR byte1 XOR byte2.
- **Accept action.** On the next edge:
  - band_breaks_mode_out is loaded from byte0;
  - pmsm_start_stop_mode_out is loaded from byte1;
  - pmsm_work_mode_out is loaded from byte2[3:0], with byte2[7:4] ignored;
  - rx_ack_out pulses;
  - the watchdog counter clears.
- **Reject action.** Any other frame seen in READY increments rx_error_count_out, which saturates at 255. The mode outputs are unchanged.

## Timing

- **Init latency.** For a rising edge sampled at clock N, the INIT state occupies cycles N+1 through N+INIT_CYCLES. can_init_done_out is high in cycle N+INIT_CYCLES+1, and READY begins at N+INIT_CYCLES+2.
- **Frame latency.** rx_ack_out and the updated mode outputs appear one cycle after the rx_valid_in cycle.
- **Frame spacing.** Back-to-back frames, one per cycle, are each handled independently.
- **Watchdog counting.** The watchdog counter runs only in READY.
- **Simultaneous events.** An accepted frame in the same cycle as the watchdog terminal count wins: the counter clears and no timeout occurs.
- **Reset mid-operation.** Asynchronous assertion clears everything immediately. After release the block waits in IDLE for a new rising edge; a level held high through reset does not count as an edge.

## Configuration

- Macro **CAN_CMD_WATCHDOG_EN**.
- **Defined:**
  - In READY the watchdog counter increments each cycle.
  - When it reaches WDT_CYCLES-1 without an accepted frame, pmsm_start_stop_mode_out is loaded with STOP_CODE and wdt_timeout_out pulses on the following edge.
  - The counter then holds and does not re-fire until an accepted frame clears it.
- **Undefined:**
  - No watchdog counter exists and wdt_timeout_out is tied to 0.
  - Outputs change only on accepted frames, restart or reset.

## Test plan

- **Init sequence.** INIT_CYCLES=10; reset; raise can_init_enable_in and hold it high -> can_init_done_out is a single pulse 11 cycles after the sampled edge; no second pulse while the level stays high.
- **Valid frame.** In READY, frame id 11'h120, dlc 4, data 32'h06_03_01_04 (byte0=04, byte1=01, byte2=03, byte3=06) -> one cycle later band_breaks_mode_out=8'h04, pmsm_start_stop_mode_out=8'h01, pmsm_work_mode_out=4'h3, rx_ack_out high for one cycle.
- **Rejects.** Bad checksum (byte3=8'h07), wrong id 11'h121, dlc 3 -> no ack, outputs unchanged, rx_error_count_out=3. A further 300 bad frames -> count saturates at 255.
- **Frames outside READY.** A valid frame in IDLE and one during INIT -> ignored, error count stays 0.
- **Restart during init.** Raise a second rising edge at INIT count 5 -> counter restarts, done pulse arrives 11 cycles after the second edge, outputs are cleared.
- **Watchdog.** With CAN_CMD_WATCHDOG_EN and WDT_CYCLES=100, after a start frame (byte1=01) send nothing -> pmsm_start_stop_mode_out=8'h00 and wdt_timeout_out pulses exactly once. With the macro undefined, the output stays 8'h01.
